// File: rtl/bcrypt_pkg.sv
// rtl/bcrypt_pkg.sv - shared types, sizes and radix-64 alphabet for the bcrypt string encoder
package bcrypt_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    PREFIX = 3'd1,
    COST   = 3'd2,
    SEP    = 3'd3,
    SALT   = 3'd4,
    CT     = 3'd5
  } enc_state_t;

  localparam int SALT_CHARS = 22;
  localparam int CT_CHARS   = 31;
  localparam int CT_BITS    = 184;
  localparam int HASH_W     = 326;
  localparam int STR_LEN    = 60;

  // bcrypt alphabet "./A-Za-z0-9", which is not the RFC 4648 ordering
  function automatic logic [7:0] b64_ascii(input logic [5:0] idx);
    logic [7:0] i8;
    i8 = {2'b00, idx};
    if (idx < 6'd2)
      b64_ascii = 8'h2E + i8;
    else if (idx < 6'd28)
      b64_ascii = 8'h41 + i8 - 8'd2;
    else if (idx < 6'd54)
      b64_ascii = 8'h61 + i8 - 8'd28;
    else
      b64_ascii = 8'h30 + i8 - 8'd54;
  endfunction

endpackage

// File: rtl/bcrypt_b64_lut.sv
// rtl/bcrypt_b64_lut.sv - combinational 6-bit index to bcrypt radix-64 ASCII
module bcrypt_b64_lut
  import bcrypt_pkg::*;
(
  input  logic [5:0] idx,
  output logic [7:0] ascii
);

  assign ascii = b64_ascii(idx);

endmodule

// File: rtl/bcrypt_hash_encoder.sv
// rtl/bcrypt_hash_encoder.sv - streams {cost, salt, ciphertext} as a 60-char "$2b$CC$..." bcrypt string
module bcrypt_hash_encoder
  import bcrypt_pkg::*;
#(
  parameter logic [7:0] MINOR_CHAR = 8'h62
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              hash_valid,
  input  logic [HASH_W-1:0] hash,
  output logic              hash_ready,
  output logic [7:0]        out_char,
  output logic              out_valid,
  input  logic              out_ready,
  output logic              out_last,
  output logic              busy
);

  enc_state_t          state;
  enc_state_t          next_state;
  logic [5:0]          pos;
  logic [5:0]          cost_r;
  logic [127:0]        salt_sr;
  logic [CT_BITS-1:0]  ct_sr;
  logic                accept;
  logic                last_in_state;
  logic [5:0]          b64_idx;
  logic [7:0]          b64_char;
  logic [2:0]          tens;
  logic [5:0]          units;
  logic                unused_ct_tail;

  // only 23 ciphertext bytes are encoded; the last byte is dropped at capture
  assign unused_ct_tail = ^hash[7:0];

  assign accept     = out_valid & out_ready;
  assign out_valid  = (state != IDLE);
  assign out_last   = (state == CT) && (pos == 6'(CT_CHARS - 1));
  assign hash_ready = (state == IDLE);
  assign busy       = ~hash_ready;

  assign b64_idx = (state == SALT) ? salt_sr[127:122] : ct_sr[CT_BITS-1 -: 6];

  bcrypt_b64_lut u_lut (
    .idx   (b64_idx),
    .ascii (b64_char)
  );

  always_comb begin
    tens  = 3'd0;
    units = cost_r;
    if (cost_r >= 6'd60) begin
      tens  = 3'd6;
      units = cost_r - 6'd60;
    end else if (cost_r >= 6'd50) begin
      tens  = 3'd5;
      units = cost_r - 6'd50;
    end else if (cost_r >= 6'd40) begin
      tens  = 3'd4;
      units = cost_r - 6'd40;
    end else if (cost_r >= 6'd30) begin
      tens  = 3'd3;
      units = cost_r - 6'd30;
    end else if (cost_r >= 6'd20) begin
      tens  = 3'd2;
      units = cost_r - 6'd20;
    end else if (cost_r >= 6'd10) begin
      tens  = 3'd1;
      units = cost_r - 6'd10;
    end
  end

  always_comb begin
    out_char = 8'h00;
    case (state)
      PREFIX: begin
        case (pos)
          6'd0:    out_char = 8'h24;
          6'd1:    out_char = 8'h32;
          6'd2:    out_char = MINOR_CHAR;
          default: out_char = 8'h24;
        endcase
      end
      COST:      out_char = (pos == 6'd0) ? (8'h30 + {5'd0, tens}) : (8'h30 + {2'd0, units});
      SEP:       out_char = 8'h24;
      SALT, CT:  out_char = b64_char;
      default:   out_char = 8'h00;
    endcase
  end

  always_comb begin
    last_in_state = 1'b0;
    next_state    = state;
    case (state)
      PREFIX: begin
        last_in_state = (pos == 6'd3);
        next_state    = COST;
      end
      COST: begin
        last_in_state = (pos == 6'd1);
        next_state    = SEP;
      end
      SEP: begin
        last_in_state = 1'b1;
        next_state    = SALT;
      end
      SALT: begin
        last_in_state = (pos == 6'(SALT_CHARS - 1));
        next_state    = CT;
      end
      CT: begin
        last_in_state = (pos == 6'(CT_CHARS - 1));
        next_state    = IDLE;
      end
      default: begin
        last_in_state = 1'b0;
        next_state    = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= IDLE;
      pos     <= 6'd0;
      cost_r  <= 6'd0;
      salt_sr <= '0;
      ct_sr   <= '0;
    end else if (state == IDLE) begin
      if (hash_valid) begin
        state   <= PREFIX;
        pos     <= 6'd0;
        cost_r  <= hash[325:320];
        salt_sr <= hash[319:192];
        ct_sr   <= hash[191:8];
      end
    end else if (accept) begin
      if (last_in_state) begin
        state <= next_state;
        pos   <= 6'd0;
      end else begin
        pos <= pos + 6'd1;
      end
      // zero fill makes the short final salt/CT characters come out padded
      if (state == SALT)
        salt_sr <= {salt_sr[121:0], 6'd0};
      if (state == CT)
        ct_sr <= {ct_sr[CT_BITS-7:0], 6'd0};
    end
  end

endmodule

// File: tb/tb_bcrypt_hash_encoder.sv
// tb/tb_bcrypt_hash_encoder.sv - directed and randomized-stall bench for bcrypt_hash_encoder
module tb_bcrypt_hash_encoder;

  logic         clk = 1'b0;
  logic         rst;
  logic         hash_valid;
  logic [325:0] hash;
  logic         hash_ready;
  logic [7:0]   out_char;
  logic         out_valid;
  logic         out_ready;
  logic         out_last;
  logic         busy;

  int n_checks = 0;
  int n_fail   = 0;
  int edge_cnt = 0;
  string alpha = "./ABCDEFGHIJKLMNOPQRSTUVWXYZabcdefghijklmnopqrstuvwxyz0123456789";

  bcrypt_hash_encoder #(.MINOR_CHAR(8'h62)) dut (
    .clk        (clk),
    .rst        (rst),
    .hash_valid (hash_valid),
    .hash       (hash),
    .hash_ready (hash_ready),
    .out_char   (out_char),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_last   (out_last),
    .busy       (busy)
  );

  always #5 clk = ~clk;
  always @(posedge clk) edge_cnt++;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic string rep(input byte c, input int n);
    string s;
    s = "";
    for (int i = 0; i < n; i++) s = {s, $sformatf("%c", c)};
    return s;
  endfunction

  function automatic string model(input logic [5:0] c, input logic [127:0] s, input logic [191:0] t);
    string r;
    logic [5:0] v;
    int p;
    r = $sformatf("$2b$%02d$", c);
    for (int i = 0; i < 22; i++) begin
      v = 6'd0;
      for (int b = 0; b < 6; b++) begin
        p = 127 - (6 * i + b);
        v = {v[4:0], (p >= 0) ? s[p] : 1'b0};
      end
      r = {r, $sformatf("%c", alpha[v])};
    end
    for (int i = 0; i < 31; i++) begin
      v = 6'd0;
      for (int b = 0; b < 6; b++) begin
        p = 191 - (6 * i + b);
        v = {v[4:0], (p >= 8) ? t[p] : 1'b0};
      end
      r = {r, $sformatf("%c", alpha[v])};
    end
    return r;
  endfunction

  task automatic load(input logic [5:0] c, input logic [127:0] s, input logic [191:0] t,
                      input bit hold, output int cap);
    int w;
    w = 0;
    @(negedge clk);
    while (!hash_ready && w < 200) begin
      @(negedge clk);
      w++;
    end
    chk("load_ready", hash_ready, 1);
    hash       = {c, s, t};
    hash_valid = 1'b1;
    @(negedge clk);
    cap = edge_cnt;
    if (!hold) hash_valid = 1'b0;
  endtask

  task automatic collect(input string exp, input int stall_pct, input string tag);
    int idx;
    int cyc;
    bit held;
    logic [7:0] hc;
    logic hl;
    idx  = 0;
    cyc  = 0;
    held = 0;
    hc   = 8'h00;
    hl   = 1'b0;
    while (idx < 60 && cyc < 3000) begin
      if (out_valid) begin
        if (held) begin
          chk({tag, "_hold"}, {out_char, out_last}, {hc, hl});
        end else begin
          chk($sformatf("%s_char%0d", tag, idx + 1), out_char, exp[idx]);
          chk($sformatf("%s_last%0d", tag, idx + 1), out_last, (idx == 59));
        end
        if ($urandom_range(99) < stall_pct) begin
          out_ready = 1'b0;
          held      = 1;
          hc        = out_char;
          hl        = out_last;
        end else begin
          out_ready = 1'b1;
          held      = 0;
          idx++;
        end
      end else if (idx > 0) begin
        chk({tag, "_valid_gap"}, out_valid, 1);
        idx = 60;
      end
      @(negedge clk);
      cyc++;
    end
    if (cyc >= 3000) chk({tag, "_timeout"}, idx, 60);
    out_ready = 1'b1;
    chk({tag, "_end_valid"}, out_valid, 0);
    chk({tag, "_end_last"}, out_last, 0);
    chk({tag, "_end_ready"}, hash_ready, 1);
  endtask

  initial begin
    int cap;
    logic [5:0]   rc;
    logic [127:0] rs;
    logic [191:0] rt;
    logic [127:0] rs2;
    logic [191:0] rt2;
    string e1;

    rst        = 1'b1;
    hash_valid = 1'b0;
    hash       = '0;
    out_ready  = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_valid", out_valid, 0);
    chk("rst_char", out_char, 0);
    chk("rst_last", out_last, 0);
    chk("rst_hash_ready", hash_ready, 1);
    chk("rst_busy", busy, 0);
    rst = 1'b0;

    // all-zero data: every radix-64 digit is '.'
    out_ready = 1'b1;
    load(6'd12, '0, '0, 0, cap);
    chk("t1_busy", busy, 1);
    collect({"$2b$12$", rep(8'h2E, 53)}, 0, "t1");
    chk("t1_ready_at", edge_cnt - cap + 1, 61);

    load(6'd5, '1, '1, 0, cap);
    collect({"$2b$05$", rep(8'h39, 21), "u", rep(8'h39, 30), "6"}, 0, "t2");

    load(6'd10, 128'h0123_4567_89AB_CDEF_FEDC_BA98_7654_3210, '0, 0, cap);
    collect({"$2b$10$.QLDX2kpxc981JoWbjOwC.", rep(8'h2E, 31)}, 0, "t3");

    for (int k = 0; k < 3; k++) begin
      rc = 6'($urandom_range(63));
      rs = {$urandom, $urandom, $urandom, $urandom};
      rt = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
      load(rc, rs, rt, 0, cap);
      collect(model(rc, rs, rt), 30, "t4");
    end

    // hash_valid held high, hash swapped mid-string
    rc  = 6'd7;
    rs  = {$urandom, $urandom, $urandom, $urandom};
    rt  = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
    rs2 = ~rs;
    rt2 = ~rt;
    load(rc, rs, rt, 1, cap);
    fork
      collect(model(rc, rs, rt), 0, "t5a");
      begin
        repeat (20) @(negedge clk);
        hash = {6'd44, rs2, rt2};
      end
    join
    collect(model(6'd44, rs2, rt2), 0, "t5b");
    hash_valid = 1'b0;

    // async reset mid-string, then a fresh string
    rt = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
    load(6'd20, rs, rt, 0, cap);
    repeat (29) @(negedge clk);
    e1 = model(6'd20, rs, rt);
    chk("t6_char30", out_char, e1[29]);
    rst = 1'b1;
    #1;
    chk("t6_rst_valid", out_valid, 0);
    chk("t6_rst_char", out_char, 0);
    chk("t6_rst_last", out_last, 0);
    chk("t6_rst_ready", hash_ready, 1);
    chk("t6_rst_busy", busy, 0);
    @(negedge clk);
    rst = 1'b0;
    load(6'd31, rs2, rt, 0, cap);
    collect(model(6'd31, rs2, rt), 0, "t6");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
